// File: rtl/adder_share_arb.sv
// Shared-adder arbiter: grants one of two requesters per cycle, adds its operands and
// holds the (ADDR_W+1)-bit result in a single-entry valid/ready output register.
module adder_share_arb #(
  parameter int unsigned ADDR_W = 64,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [ADDR_W-1:0] i_req0_a,
  input  logic [ADDR_W-1:0] i_req0_b,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [ADDR_W-1:0] i_req1_a,
  input  logic [ADDR_W-1:0] i_req1_b,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [ADDR_W-1:0] o_res_sum,
  output logic              o_res_carry,
  output logic              o_res_id
);

  typedef enum logic {StEmpty, StFull} out_state_e;

  out_state_e        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              id_q, id_d;

  logic              can_accept;
  logic              gnt0, gnt1;
  logic              accept;
  logic [ADDR_W-1:0] op_a, op_b;
  logic [ADDR_W:0]   sum_full;

  // Grant selection and operand mux; a FULL stage only frees up when the consumer takes it.
  always_comb begin
    can_accept = (state_q == StEmpty) || i_res_ready;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      // rr_last_q is the last requester served; the other one goes next
      if (RR_EN && !rr_last_q) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = 1'b1;
      end
    end else begin
      gnt0 = i_req0_valid;
      gnt1 = i_req1_valid;
    end
    accept   = can_accept && (gnt0 || gnt1);
    op_a     = gnt1 ? i_req1_a : i_req0_a;
    op_b     = gnt1 ? i_req1_b : i_req0_b;
    sum_full = {1'b0, op_a} + {1'b0, op_b};
  end

  // Next-state for the output stage and round-robin pointer.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    id_d      = id_q;
    if (accept) begin
      state_d   = StFull;
      rr_last_d = gnt1;
      sum_d     = sum_full[ADDR_W-1:0];
      carry_d   = sum_full[ADDR_W];
      id_d      = gnt1;
    end else if (i_res_ready) begin
      // Result consumed with nothing new to replace it; data bits simply hold
      state_d = StEmpty;
    end
  end

  // State registers; reset points rr_last at requester 1 so requester 0 wins first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StEmpty;
      rr_last_q <= 1'b1;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      id_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      id_q      <= id_d;
    end
  end

  // Readies are gated by reset so nothing is reported accepted while i_rst is high.
  always_comb begin
    o_req0_ready = can_accept && gnt0 && !i_rst;
    o_req1_ready = can_accept && gnt1 && !i_rst;
    o_res_valid  = (state_q == StFull);
    o_res_sum    = sum_q;
    o_res_carry  = carry_q;
    o_res_id     = id_q;
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed and random checks for adder_share_arb, with a round-robin and a fixed-priority
// instance driven by the same requester stimulus.
module tb_adder_share_arb;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1, res_ready;
  logic [W-1:0] a0, b0, a1, b1;

  logic         r0, r1, rv, carry, id;
  logic [W-1:0] sum;
  logic         fp_r0, fp_r1, fp_rv, fp_carry, fp_id;
  logic [W-1:0] fp_sum;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_share_arb #(.ADDR_W(W), .RR_EN(1'b1)) u_dut_rr (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req0_valid(v0),
    .o_req0_ready(r0),
    .i_req0_a    (a0),
    .i_req0_b    (b0),
    .i_req1_valid(v1),
    .o_req1_ready(r1),
    .i_req1_a    (a1),
    .i_req1_b    (b1),
    .o_res_valid (rv),
    .i_res_ready (res_ready),
    .o_res_sum   (sum),
    .o_res_carry (carry),
    .o_res_id    (id)
  );

  adder_share_arb #(.ADDR_W(W), .RR_EN(1'b0)) u_dut_fp (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req0_valid(v0),
    .o_req0_ready(fp_r0),
    .i_req0_a    (a0),
    .i_req0_b    (b0),
    .i_req1_valid(v1),
    .o_req1_ready(fp_r1),
    .i_req1_a    (a1),
    .i_req1_b    (b1),
    .o_res_valid (fp_rv),
    .i_res_ready (res_ready),
    .o_res_sum   (fp_sum),
    .o_res_carry (fp_carry),
    .o_res_id    (fp_id)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W+1:0] sb_q[$];
  logic [W+1:0] exp_e;
  logic [W:0]   full;
  bit           acc0, acc1;
  int           w0, w1, max_wait;

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #1;
    check_eq("rst_valid", rv, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_carry", carry, 0);
    check_eq("rst_id", id, 0);
    check_eq("rst_ready0", r0, 0);
    step();
    rst = 1'b0;

    // Single req0: 0x1000 + 4
    v0 = 1'b1; a0 = 64'h1000; b0 = 64'd4; res_ready = 1'b1;
    #1;
    check_eq("single_ready0", r0, 1);
    check_eq("single_ready1", r1, 0);
    step();
    v0 = 1'b0;
    check_eq("single_valid", rv, 1);
    check_eq("single_sum", sum, 64'h1004);
    check_eq("single_carry", carry, 0);
    check_eq("single_id", id, 0);
    step();
    check_eq("drain_empty", rv, 0);

    // Fill with a req0 result (rr_last=0), then reset mid-stream
    v0 = 1'b1; a0 = 64'd5; b0 = 64'd6;
    step();
    v0 = 1'b0;
    check_eq("prefill_valid", rv, 1);
    check_eq("prefill_sum", sum, 64'd11);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", rv, 0);
    check_eq("midrst_sum", sum, 0);
    step();
    rst = 1'b0;

    // Both valid for 4 cycles: RR gives 0,1,0,1; fixed priority gives 0,0,0,0
    v0 = 1'b1; a0 = 64'h100; b0 = 64'd1;
    v1 = 1'b1; a1 = 64'h200; b1 = 64'd2;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("rr_ready0", r0, (k % 2) == 0);
      check_eq("rr_ready1", r1, (k % 2) == 1);
      step();
      check_eq("rr_id", id, k % 2);
      check_eq("rr_sum", sum, (k % 2) ? 64'h202 : 64'h101);
      check_eq("fp_id", fp_id, 0);
      check_eq("fp_sum", fp_sum, 64'h101);
    end

    // Backpressure: hold FULL for 3 cycles with both still valid
    res_ready = 1'b0;
    #1;
    check_eq("bp_ready0", r0, 0);
    check_eq("bp_ready1", r1, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("bp_valid", rv, 1);
      check_eq("bp_sum", sum, 64'h202);
      check_eq("bp_id", id, 1);
      check_eq("bp_ready0_hold", r0, 0);
      check_eq("bp_ready1_hold", r1, 0);
    end
    res_ready = 1'b1;
    #1;
    check_eq("release_ready0", r0, 1);
    check_eq("release_ready1", r1, 0);
    step();
    check_eq("release_id", id, 0);
    check_eq("release_sum", sum, 64'h101);
    v0 = 1'b0; v1 = 1'b0;
    step();
    check_eq("release_empty", rv, 0);

    // Wrap-around
    v0 = 1'b1; a0 = 64'hFFFF_FFFF_FFFF_FFFC; b0 = 64'd4;
    step();
    v0 = 1'b0;
    check_eq("wrap1_sum", sum, 0);
    check_eq("wrap1_carry", carry, 1);
    check_eq("wrap1_id", id, 0);
    v1 = 1'b1; a1 = '1; b1 = '1;
    step();
    v1 = 1'b0;
    check_eq("wrap2_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("wrap2_carry", carry, 1);
    check_eq("wrap2_id", id, 1);
    step();

    // Random traffic against an in-order scoreboard
    w0 = 0; w1 = 0; max_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!v0 && ($urandom_range(1) == 1)) begin
        v0 = 1'b1; a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
      end
      if (!v1 && ($urandom_range(1) == 1)) begin
        v1 = 1'b1; a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      end
      res_ready = ($urandom_range(3) != 0);
      #1;
      if (r0 || r1) check_eq("rand_onehot", r0 && r1, 0);
      if (rv && res_ready) begin
        check_eq("rand_sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          exp_e = sb_q.pop_front();
          check_eq("rand_result", {id, carry, sum}, exp_e);
        end
      end
      if (r0) begin
        full = {1'b0, a0} + {1'b0, b0};
        sb_q.push_back({1'b0, full});
        if (v1) w1++;
        w0 = 0;
      end
      if (r1) begin
        full = {1'b0, a1} + {1'b0, b1};
        sb_q.push_back({1'b1, full});
        if (v0) w0++;
        w1 = 0;
      end
      if (w0 > max_wait) max_wait = w0;
      if (w1 > max_wait) max_wait = w1;
      acc0 = r0;
      acc1 = r1;
      step();
      if (acc0) v0 = 1'b0;
      if (acc1) v1 = 1'b0;
    end
    check_eq("rand_starve", max_wait > 1, 0);

    // Drain the last pending result
    v0 = 1'b0; v1 = 1'b0; res_ready = 1'b1;
    #1;
    if (rv) begin
      check_eq("drain_sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        check_eq("drain_result", {id, carry, sum}, exp_e);
      end
    end
    step();
    check_eq("final_empty", rv, 0);
    check_eq("final_sb_size", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
